// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/ready bus between fetch stage and memory
interface if_fetch_stage_if;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ready;
  logic [31:0] IM_Data;

  modport master (
    output IM_Req,
    output IM_Addr,
    input  IM_Ready,
    input  IM_Data
  );

  modport slave (
    input  IM_Req,
    input  IM_Addr,
    output IM_Ready,
    output IM_Data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with variable-latency memory and IF/ID register
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    PCWrite,
  input  logic                    IFIDWrite,
  input  logic [1:0]              ID_PCSrc,
  input  logic [31:0]             ID_BranchAddr,
  input  logic [31:0]             ID_JumpAddr,
  input  logic [31:0]             ID_JrRsData,
  input  logic                    IF_Flush,
  if_fetch_stage_if.master        im,
  output logic [31:0]             ID_Instruction,
  output logic [31:0]             ID_PCplus4,
  output logic [31:0]             IF_PC,
  output logic                    FetchStall
);

  // FETCH: request outstanding; HOLD: word parked while the pipe is stalled;
  // DRAIN: a redirect arrived mid-request, so the old request must finish first.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pcplus4;
  logic [31:0] r_hold;
  logic [31:0] r_saved;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_advance;
  logic        w_redirect;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_advance  = PCWrite & IFIDWrite;
  assign w_redirect = IFIDWrite & (ID_PCSrc != 2'b00);

  // Select the redirect target; word alignment is enforced here so every PC load is aligned.
  always_comb begin
    w_target = ID_BranchAddr;
    case (ID_PCSrc)
      2'b10:   w_target = ID_JumpAddr;
      2'b11:   w_target = ID_JrRsData;
      default: w_target = ID_BranchAddr;
    endcase
    w_target[1:0] = 2'b00;
  end

  assign im.IM_Addr     = r_pc;
  assign im.IM_Req      = Reset & (r_state != S_HOLD);
  assign FetchStall     = ((r_state == S_FETCH) & ~im.IM_Ready) | (r_state == S_DRAIN);
  assign ID_Instruction = r_id_instr;
  assign ID_PCplus4     = r_id_pcplus4;
  assign IF_PC          = r_pc;

  // Fetch FSM, PC and IF/ID register; a bubble is the default IF/ID write and is overridden only when a real word is delivered.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_id_instr   <= NOP;
      r_id_pcplus4 <= 32'd0;
      r_hold       <= 32'd0;
      r_saved      <= 32'd0;
    end else begin
      if (IFIDWrite) begin
        r_id_pcplus4 <= w_pc_plus4;
        r_id_instr   <= NOP;
      end
      case (r_state)
        S_FETCH: begin
          if (im.IM_Ready) begin
            if (w_redirect) begin
              r_pc <= w_target;
            end else if (w_advance) begin
              r_pc <= w_pc_plus4;
              if (!IF_Flush) begin
                r_id_instr <= im.IM_Data;
              end
            end else begin
              r_hold  <= im.IM_Data;
              r_state <= S_HOLD;
            end
          end else if (w_redirect) begin
            r_saved <= w_target;
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (w_advance) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_FETCH;
            if (!IF_Flush) begin
              r_id_instr <= r_hold;
            end
          end
        end
        S_DRAIN: begin
          if (im.IM_Ready) begin
            r_pc    <= r_saved;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pcw, ifw, flush;
  logic [1:0]  src;
  logic [31:0] baddr, jaddr, jraddr;
  logic [31:0] id_i, id_p, if_pc;
  logic        fstall;

  if_fetch_stage_if imb();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  assign imb.IM_Data = mem_word(imb.IM_Addr);

  if_fetch_stage #(.RESET_PC(32'h0), .NOP(NOP)) dut (
    .Clock          (clk),
    .Reset          (rst_n),
    .PCWrite        (pcw),
    .IFIDWrite      (ifw),
    .ID_PCSrc       (src),
    .ID_BranchAddr  (baddr),
    .ID_JumpAddr    (jaddr),
    .ID_JrRsData    (jraddr),
    .IF_Flush       (flush),
    .im             (imb),
    .ID_Instruction (id_i),
    .ID_PCplus4     (id_p),
    .IF_PC          (if_pc),
    .FetchStall     (fstall)
  );

  typedef struct {
    logic        req;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  // reference model state: what the fetch unit "knows"
  logic [31:0] m_pc, m_held, m_drain_tgt, m_id_i, m_id_p;
  bit          m_holding, m_draining;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_held = 32'h0; m_drain_tgt = 32'h0;
    m_id_i = NOP; m_id_p = 32'h0;
    m_holding = 0; m_draining = 0;
  endtask

  task automatic model_step();
    logic [31:0] tgt, word;
    bit adv, redir, word_ok;
    tgt = (src == 2'b01) ? baddr : (src == 2'b10) ? jaddr : jraddr;
    tgt = tgt & 32'hFFFF_FFFC;
    adv = pcw && ifw;
    redir = ifw && (src != 2'b00);
    word_ok = m_holding || (!m_draining && imb.IM_Ready);
    word = m_holding ? m_held : mem_word(m_pc);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ifw) begin
        m_id_p = m_pc + 32'd4;
        m_id_i = (word_ok && adv && !redir && !flush) ? word : NOP;
      end
      if (m_draining) begin
        if (imb.IM_Ready) begin
          m_pc = m_drain_tgt;
          m_draining = 0;
        end
      end else if (redir) begin
        if (word_ok) begin
          m_pc = tgt;
          m_holding = 0;
        end else begin
          m_drain_tgt = tgt;
          m_draining = 1;
        end
      end else if (word_ok && adv) begin
        m_pc = m_pc + 32'd4;
        m_holding = 0;
      end else if (word_ok && !m_holding) begin
        m_held = word;
        m_holding = 1;
      end
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 255));
  endfunction

  // monitor: compare DUT against the oldest expectation, away from the clock edge
  always @(negedge clk) begin
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("im_req", {31'b0, imb.IM_Req}, {31'b0, e.req});
      chk("im_addr", imb.IM_Addr, e.pc);
      chk("if_pc", if_pc, e.pc);
      chk("fetch_stall", {31'b0, fstall}, {31'b0, e.stall});
      chk("id_instruction", id_i, e.instr);
      chk("id_pcplus4", id_p, e.pcp4);
    end
  end

  initial begin
    exp_t x;
    bit zero_wait;
    rst_n = 1'b0; pcw = 1'b0; ifw = 1'b0; flush = 1'b0; src = 2'b00;
    baddr = 32'h0; jaddr = 32'h0; jraddr = 32'h0;
    imb.IM_Ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_id_instruction", id_i, NOP);
    chk("rst_id_pcplus4", id_p, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_im_req", {31'b0, imb.IM_Req}, 32'h0);
    chk("rst_fetch_stall", {31'b0, fstall}, 32'h1);
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      zero_wait = ((cyc / 200) % 3) == 0;
      rst_n  = ($urandom_range(0, 199) != 0);
      pcw    = zero_wait ? 1'b1 : ($urandom_range(0, 9) < 8);
      ifw    = zero_wait ? 1'b1 : ($urandom_range(0, 9) < 8);
      flush  = ($urandom_range(0, 4) == 0);
      src    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      baddr  = rand_tgt();
      jaddr  = rand_tgt();
      jraddr = rand_tgt();
      imb.IM_Ready = zero_wait ? 1'b1 : ($urandom_range(0, 9) < 6);
      x.req   = rst_n && !m_holding;
      x.stall = m_draining || (!m_holding && !imb.IM_Ready);
      x.pc    = m_pc;
      x.instr = m_id_i;
      x.pcp4  = m_id_p;
      q.push_back(x);
      model_step();
    end

    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
